// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// The optional checksum stage is enabled by defining IMEM_LOADER_CSUM_EN.
package imem_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  // States in which the loader accepts stream bytes.
  function automatic logic accepts_bytes(state_e s);
    return s inside {ST_SYNC, ST_CNT_HI, ST_CNT_LO, ST_DATA_HI, ST_DATA_LO, ST_CSUM};
  endfunction

endpackage

// File: rtl/imem_loader_csum.sv
// XOR accumulator over the frame's data bytes, compared against the trailing checksum byte.
// Instantiated by imem_loader only when IMEM_LOADER_CSUM_EN is defined.
module imem_loader_csum
  import imem_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [BYTE_W-1:0] data_i,
  input  logic [BYTE_W-1:0] cmp_i,
  output logic              match_o
);

  logic [BYTE_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q ^ data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign match_o = (acc_q == cmp_i);

endmodule

// File: rtl/imem_loader.sv
// Program loader: parses a framed byte stream into 16-bit words and writes them to instruction memory,
// holding the CPU while loading. Define IMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                MEM_DEPTH = 256,
  parameter logic [WORD_W-1:0] BASE_ADDR = 16'h0000,
  parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [BYTE_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              imem_we_o,
  output logic [WORD_W-1:0] imem_addr_o,
  output logic [WORD_W-1:0] imem_wdata_o,
  output logic              cpu_hold_o,
  output logic              load_done_o,
  output logic              load_err_o,
  output logic [WORD_W-1:0] words_loaded_o
);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [BYTE_W-1:0] cnt_hi_q, cnt_hi_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] idx_q, idx_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] words_q, words_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;
  logic [WORD_W-1:0] cnt_w;
  state_e            after_data;

  assign rx_ready_o = accepts_bytes(state_q);
  assign xfer       = rx_valid_i && rx_ready_o;
  assign cnt_w      = {cnt_hi_q, rx_data_i};

`ifdef IMEM_LOADER_CSUM_EN
  logic csum_clr, csum_en, csum_match;

  assign after_data = ST_CSUM;
  assign csum_clr   = (state_q inside {ST_IDLE, ST_DONE, ST_ERR}) && start_i;
  assign csum_en    = xfer && (state_q inside {ST_DATA_HI, ST_DATA_LO});

  imem_loader_csum u_csum (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (csum_clr),
    .en_i    (csum_en),
    .data_i  (rx_data_i),
    .cmp_i   (rx_data_i),
    .match_o (csum_match)
  );
`else
  assign after_data = ST_DONE;
`endif

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    cnt_hi_d = cnt_hi_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    words_d  = words_q;
    hold_d   = hold_q;
    done_d   = done_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_d = ST_SYNC;
          done_d  = 1'b0;
          err_d   = 1'b0;
          words_d = '0;
          idx_d   = '0;
          hold_d  = 1'b1;
        end
      end
      ST_SYNC: if (xfer && rx_data_i == SYNC_BYTE) state_d = ST_CNT_HI;
      ST_CNT_HI: begin
        if (xfer) begin
          cnt_hi_d = rx_data_i;
          state_d  = ST_CNT_LO;
        end
      end
      ST_CNT_LO: begin
        if (xfer) begin
          cnt_d = cnt_w;
          if (cnt_w == '0)                              state_d = after_data;
          else if ({16'd0, cnt_w} > 32'(MEM_DEPTH))     state_d = ST_ERR;
          else                                          state_d = ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        if (xfer) begin
          hi_d    = rx_data_i;
          state_d = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (xfer) begin
          we_d    = 1'b1;
          addr_d  = BASE_ADDR + idx_q;
          wdata_d = {hi_q, rx_data_i};
          words_d = words_q + 16'd1;
          idx_d   = idx_q + 16'd1;
          state_d = (idx_q + 16'd1 == cnt_q) ? after_data : ST_DATA_HI;
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      ST_CSUM: if (xfer) state_d = csum_match ? ST_DONE : ST_ERR;
`endif
      default: state_d = ST_IDLE;
    endcase

    // Status flags follow the terminal state entered; the CPU stays held on error.
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      done_d = 1'b1;
      hold_d = 1'b0;
    end
    if (state_d == ST_ERR && state_q != ST_ERR) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      hi_q     <= '0;
      cnt_hi_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      words_q  <= '0;
      hold_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      cnt_hi_q <= cnt_hi_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      words_q  <= words_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign imem_we_o      = we_q;
  assign imem_addr_o    = addr_q;
  assign imem_wdata_o   = wdata_q;
  assign cpu_hold_o     = hold_q;
  assign load_done_o    = done_q;
  assign load_err_o     = err_q;
  assign words_loaded_o = words_q;

endmodule
